// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side engine for the 8-bit synchronous FIFO.
// Pops bytes in bursts of BURST_LEN (or a shorter flush burst) and streams
// them out on a valid/ready port, marking the final byte with out_last.
// Optional feature macro: FIFO_BURST_READER_PARITY_EN adds out_parity.
//
// Handshake: a byte moves when out_valid & out_ready are both high at a
// rising edge; while out_valid is high and out_ready is low, out_data,
// out_last (and out_parity) are held unchanged; out_valid never drops
// before the byte is accepted.
//
// Buffering: slot 0 is the output register; slots 1..2 form the skid
// buffer. Pops are throttled on (skid occupancy + reads in flight) < 2,
// using registered state only, so out_ready never reaches r_enable
// combinationally while a full-rate stream still fits.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_count,
  output logic                  r_enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
`ifdef FIFO_BURST_READER_PARITY_EN
  output logic                  out_parity,
`endif
  output logic [1:0]            o_dbg_state
);

  localparam logic [7:0] LP_BURST = 8'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_rem;
  logic [7:0]            w_rem_nxt;
  logic                  w_pop;
  logic                  w_start;
  logic                  r_flush_pend;
  logic                  r_inflight;
  logic                  r_inflight_last;

  logic [DATA_WIDTH-1:0] r_slot_data [3];
  logic [DATA_WIDTH-1:0] w_data_nxt  [3];
  logic [2:0]            r_slot_last;
  logic [2:0]            w_last_nxt;
  logic [1:0]            r_cnt;
  logic [1:0]            w_cnt_mid;
  logic [1:0]            w_cnt_nxt;
  logic [1:0]            w_skid_occ;
  logic                  w_room;
  logic                  w_xfer;

`ifdef FIFO_BURST_READER_PARITY_EN
  logic [2:0]            r_slot_par;
  logic [2:0]            w_par_nxt;
`endif

  assign out_valid   = (r_cnt != 2'd0);
  assign out_data    = r_slot_data[0];
  assign out_last    = r_slot_last[0] & out_valid;
  assign w_xfer      = out_valid & out_ready;
  assign busy        = (r_state != S_IDLE);
  assign r_enable    = w_pop;
  assign o_dbg_state = r_state;
`ifdef FIFO_BURST_READER_PARITY_EN
  assign out_parity  = r_slot_par[0];
`endif

  // Bytes beyond the output register, plus the read still on its way.
  assign w_skid_occ = (r_cnt > 2'd1) ? (r_cnt - 2'd1) : 2'd0;
  assign w_room     = ((w_skid_occ + {1'b0, r_inflight}) < 2'd2);

  // Burst FSM: next state, remaining-byte count and the pop strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fifo_count >= LP_BURST) begin
          w_start     = 1'b1;
          w_rem_nxt   = LP_BURST;
          w_state_nxt = S_BURST;
        end else if (r_flush_pend && (fifo_count != 8'd0)) begin
          w_start     = 1'b1;
          w_rem_nxt   = fifo_count;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if ((r_rem != 8'd0) && !fifo_empty && w_room) begin
          w_pop     = 1'b1;
          w_rem_nxt = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((r_cnt == 2'd0) && !r_inflight) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, remaining count, flush request and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_rem           <= 8'd0;
      r_flush_pend    <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_rem           <= w_rem_nxt;
      r_inflight      <= w_pop;
      r_inflight_last <= w_pop && (r_rem == 8'd1);
      // A new flush wins over the clear so a request arriving on the
      // cycle a burst starts is still served at the following IDLE.
      if (flush && (fifo_count != 8'd0)) begin
        r_flush_pend <= 1'b1;
      end else if (w_start) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  // Slot queue update: shift out on transfer, append the arriving byte.
  always_comb begin
    w_data_nxt = r_slot_data;
    w_last_nxt = r_slot_last;
    w_cnt_mid  = r_cnt;
`ifdef FIFO_BURST_READER_PARITY_EN
    w_par_nxt  = r_slot_par;
`endif
    if (w_xfer) begin
      w_data_nxt[0] = r_slot_data[1];
      w_data_nxt[1] = r_slot_data[2];
      w_last_nxt    = {1'b0, r_slot_last[2:1]};
      w_cnt_mid     = r_cnt - 2'd1;
`ifdef FIFO_BURST_READER_PARITY_EN
      w_par_nxt     = {1'b0, r_slot_par[2:1]};
`endif
    end
    w_cnt_nxt = w_cnt_mid;
    if (r_inflight) begin
      case (w_cnt_mid)
        2'd0: begin
          w_data_nxt[0] = fifo_data;
          w_last_nxt[0] = r_inflight_last;
`ifdef FIFO_BURST_READER_PARITY_EN
          w_par_nxt[0]  = ^fifo_data;
`endif
        end
        2'd1: begin
          w_data_nxt[1] = fifo_data;
          w_last_nxt[1] = r_inflight_last;
`ifdef FIFO_BURST_READER_PARITY_EN
          w_par_nxt[1]  = ^fifo_data;
`endif
        end
        default: begin
          w_data_nxt[2] = fifo_data;
          w_last_nxt[2] = r_inflight_last;
`ifdef FIFO_BURST_READER_PARITY_EN
          w_par_nxt[2]  = ^fifo_data;
`endif
        end
      endcase
      w_cnt_nxt = w_cnt_mid + 2'd1;
    end
  end

  // Slot registers; reset drops every buffered byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_slot_data[i] <= '0;
      end
      r_slot_last <= 3'b000;
      r_cnt       <= 2'd0;
`ifdef FIFO_BURST_READER_PARITY_EN
      r_slot_par  <= 3'b000;
`endif
    end else begin
      r_slot_data <= w_data_nxt;
      r_slot_last <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef FIFO_BURST_READER_PARITY_EN
      r_slot_par  <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed plus randomized bench for fifo_burst_reader.
// The FIFO is a queue with one-cycle read latency; expected output is the
// written byte stream cut into bursts by the reader's rules.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic [7:0]    fifo_count;
  logic          r_enable;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [1:0]    dbg_state;
`ifdef FIFO_BURST_READER_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .r_enable   (r_enable),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
`ifdef FIFO_BURST_READER_PARITY_EN
    .out_parity (out_parity),
`endif
    .o_dbg_state(dbg_state)
  );

  // ---------------- model state / scoreboard ----------------
  logic [7:0] fq[$];      // FIFO contents
  logic [7:0] ref_q[$];   // written bytes not yet assigned to a burst
  logic [8:0] exp_q[$];   // {last, data} expected on the output port
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  n_pops = 0;
  int  n_xfers = 0;
  logic hold_empty = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_last = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic update_flags();
    fifo_count = 8'(fq.size());
    fifo_empty = (fq.size() == 0) || hold_empty;
  endtask

  task automatic fifo_write(input logic [7:0] b);
    fq.push_back(b);
    ref_q.push_back(b);
    update_flags();
  endtask

  // The next n written bytes form one burst, last flag on the final one.
  task automatic expect_burst(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = ref_q.pop_front();
      exp_q.push_back({(i == n - 1), b});
    end
  endtask

  // One clock: sample before the edge, model the FIFO, check transfers.
  task automatic step();
    logic did_pop, xfer, xl;
    logic [7:0] xd;
    logic [8:0] e;
`ifdef FIFO_BURST_READER_PARITY_EN
    logic xp;
    xp = out_parity;
`endif
    #1;
    did_pop = r_enable;
    if (r_enable) chk("no_pop_when_empty", fifo_empty, 0);
    if (prev_stall) begin
      chk("stall_valid_held", out_valid, 1);
      chk("stall_data_held", out_data, prev_data);
      chk("stall_last_held", out_last, prev_last);
    end
    xfer = out_valid & out_ready;
    xd = out_data;
    xl = out_last;
    prev_stall = out_valid & ~out_ready;
    prev_data = out_data;
    prev_last = out_last;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (did_pop) begin
      if (fq.size() > 0) fifo_data = fq.pop_front();
      n_pops++;
    end
    update_flags();
    if (xfer) begin
      n_xfers++;
      chk("xfer_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_data", xd, e[7:0]);
        chk("xfer_last", xl, e[8]);
`ifdef FIFO_BURST_READER_PARITY_EN
        chk("xfer_parity", xp, ^e[7:0]);
`endif
      end
    end
    if (did_pop) chk("held_bytes_le_3", ((n_pops - n_xfers) <= 3), 1);
  endtask

  // mode 0: ready always, 1: pattern 1,0,0,1, 2: random ready
  task automatic run_until_idle(input int budget, input int mode);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      step();
      c++;
    end
    out_ready = 1'b1;
    chk("drain_within_budget", (c < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_r_enable", r_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fq.delete();
    ref_q.delete();
    exp_q.delete();
    n_pops = 0;
    n_xfers = 0;
    prev_stall = 1'b0;
    hold_empty = 1'b0;
    update_flags();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c, p0, x0, k, n;
    fifo_data = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    update_flags();
    do_reset();

    // Reset mid-burst after 3 pops: nothing buffered may reappear.
    for (int i = 0; i < 16; i++) fifo_write(8'(i + 8'h10));
    expect_burst(16);
    c = 0;
    while (n_pops < 3 && c < 50) begin step(); c++; end
    chk("reach_3_pops", n_pops, 3);
    do_reset();
    repeat (20) step();
    chk("post_reset_no_pops", n_pops, 0);
    chk("post_reset_no_xfers", n_xfers, 0);
    chk("post_reset_idle", busy, 0);

    // Normal burst 0x41..0x50: timing, throughput, out_last.
    for (int i = 0; i < 16; i++) fifo_write(8'(8'h41 + i));
    expect_burst(16);
    step();
    chk("burst_busy_rise", busy, 1);
    chk("burst_valid_t1", out_valid, 0);
    step();
    chk("burst_valid_t2", out_valid, 0);
    step();
    chk("burst_valid_t3", out_valid, 1);
    x0 = n_xfers;
    repeat (16) step();
    chk("burst_full_rate", n_xfers - x0, 16);
    step();
    chk("busy_low_after_burst", busy, 0);
    chk("burst_all_seen", exp_q.size(), 0);

    // Threshold: 15 bytes do not start a burst, the 16th does.
    p0 = n_pops;
    for (int i = 0; i < 15; i++) fifo_write(8'($urandom));
    repeat (20) step();
    chk("below_threshold_no_pop", n_pops - p0, 0);
    chk("below_threshold_idle", busy, 0);
    fifo_write(8'($urandom));
    expect_burst(16);
    run_until_idle(200, 0);

    // Flush of 3 bytes, then flush with the FIFO empty.
    fifo_write(8'd150);
    fifo_write(8'd80);
    fifo_write(8'd65);
    repeat (5) step();
    flush = 1'b1;
    x0 = n_xfers;
    expect_burst(3);
    run_until_idle(100, 0);
    chk("flush_xfers", n_xfers - x0, 3);
    p0 = n_pops;
    flush = 1'b1;
    repeat (10) step();
    chk("empty_flush_no_pop", n_pops - p0, 0);
    chk("empty_flush_idle", busy, 0);

    // Backpressure 1,0,0,1.
    for (int i = 0; i < 16; i++) fifo_write(8'($urandom));
    expect_burst(16);
    x0 = n_xfers;
    run_until_idle(300, 1);
    chk("backpressure_xfers", n_xfers - x0, 16);

    // Underrun: FIFO reports empty for 5 cycles mid-burst.
    for (int i = 0; i < 16; i++) fifo_write(8'($urandom));
    expect_burst(16);
    p0 = n_pops;
    c = 0;
    while ((n_pops - p0) < 6 && c < 50) begin step(); c++; end
    chk("underrun_reach_6", n_pops - p0, 6);
    hold_empty = 1'b1;
    update_flags();
    p0 = n_pops;
    repeat (5) step();
    chk("underrun_no_pop", n_pops - p0, 0);
    chk("underrun_still_busy", busy, 1);
    hold_empty = 1'b0;
    update_flags();
    run_until_idle(200, 0);

    // Random rounds: full bursts, then a flush for the remainder.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) fifo_write(8'($urandom));
      k = n;
      while (k >= BL) begin expect_burst(BL); k -= BL; end
      run_until_idle(600, 2);
      repeat (3) step();
      chk("rand_remainder_held", fifo_count, k);
      if (k > 0) begin
        flush = 1'b1;
        expect_burst(k);
        run_until_idle(300, 2);
      end
      chk("rand_round_empty", fifo_count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
